// File: rtl/dlsc_mul32.sv
// dlsc_mul32 - iterative 32x32 multiplier, signed or unsigned, exact 64-bit
// product. One multiplier bit per clock: 32 add/shift steps, then one fix-up
// cycle that applies the sign. The start/done handshake matches the iterative
// divider, so both units can share one issue/stall path.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   multiplicand  operand A, sampled when start=1
//   multiplier    operand B, sampled when start=1
//   sign          1 = both operands two's complement, 0 = unsigned
//   start         single-cycle request; restarts the unit if it is busy
//   done          1 = idle with a valid product, 0 = busy
//   product_hi    product bits [63:32]
//   product_lo    product bits [31:0]
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | product valid, waiting for start
// ST_RUN   | add/shift step, count 0..31
// ST_FIX   | negate the magnitude if needed, publish product, raise done

module dlsc_mul32 #(
   parameter DEVICE = "GENERIC"
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   input  logic        sign,
   input  logic        start,
   output logic        done,
   output logic [31:0] product_hi,
   output logic [31:0] product_lo
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [4:0]  count;
   logic [32:0] acc;
   logic [31:0] mq;
   logic [31:0] mcand_mag;
   logic        neg;

   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] sum;
   logic [63:0] mag;
   logic [63:0] prod_res;

   // Two's complement magnitude; -2^31 maps onto 0x80000000, which is
   // exactly right when the result is read as unsigned.
   assign a_mag = (sign & multiplicand[31]) ? (32'd0 - multiplicand) : multiplicand;
   assign b_mag = (sign & multiplier[31])   ? (32'd0 - multiplier)   : multiplier;

   // No device-specific carry chain exists yet; every target uses the
   // portable adder.
   if (DEVICE == "GENERIC") begin : g_sum_generic
      assign sum = acc + {1'b0, (mq[0] ? mcand_mag : 32'd0)};
   end else begin : g_sum_other
      assign sum = acc + {1'b0, (mq[0] ? mcand_mag : 32'd0)};
   end

   assign mag      = {acc[31:0], mq};
   assign prod_res = neg ? (64'd0 - mag) : mag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = ST_IDLE;
         ST_RUN:  if (count == 5'd31) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      // start wins in every state, including FIX, so an aborted result
      // never reaches the product registers.
      if (start) begin
         state_nxt = ST_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= 5'd0;
         acc        <= 33'd0;
         mq         <= 32'd0;
         mcand_mag  <= 32'd0;
         neg        <= 1'b0;
         done       <= 1'b1;
         product_hi <= 32'd0;
         product_lo <= 32'd0;
      end else if (start) begin
         count     <= 5'd0;
         acc       <= 33'd0;
         mq        <= b_mag;
         mcand_mag <= a_mag;
         neg       <= sign & (multiplicand[31] ^ multiplier[31]);
         done      <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               // The adder carry drops into acc[31]; the bit shifted out of
               // the accumulator becomes the next product bit in mq.
               {acc, mq} <= {sum, mq} >> 1;
               count     <= count + 5'd1;
            end
            ST_FIX: begin
               {product_hi, product_lo} <= prod_res;
               done                     <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
